wash_cycle_timer: RTL and testbench
===================================

# wash_cycle_timer

Phase timer and watchdog for the washing-machine controller. It supplies the `cycle_time_out` and `spin_time_out` inputs to the sequencing FSM, replacing the testbench- or board-driven strobes. Durations come from a wash-program selector. An optional watchdog flags fill or drain phases that never complete. The block sits beside the controller FSM: it takes the FSM's phase indications as requests and returns registered timeout levels.

## Interface
- `TICK_DIV`, default 1000: clocks per timer tick, minimum 2.
- `CNT_W`, default 16: width of tick counters and `cfg_*` duration ports.
- `clk` in, 1: clock; all logic is on its rising edge.
- `reset` in, 1: the block has one clock, and `reset` is synchronous and active-low.
- `mode_sel` in, 2: program select: 00 quick, 01 normal, 10 heavy, 11 custom.
- `cfg_wash_ticks` in, CNT_W: wash duration in ticks, used in custom mode.
- `cfg_spin_ticks` in, CNT_W: spin duration in ticks, used in custom mode.
- `cfg_fill_limit` in, CNT_W: fill watchdog limit in ticks.
- `cfg_drain_limit` in, CNT_W: drain watchdog limit in ticks.
- `run_wash` in, 1: wash-phase request, level.
- `run_spin` in, 1: spin-phase request, level.
- `fill_active` in, 1: fill valve open.
- `drain_active` in, 1: drain valve open, outside spin.
- `fault_clr` in, 1: clears sticky faults (single-cycle pulse).
- `cycle_time_out` out, 1: wash duration elapsed.
- `spin_time_out` out, 1: spin duration elapsed.
- `fill_fault` out, 1: fill exceeded its limit; sticky.
- `drain_fault` out, 1: drain exceeded its limit; sticky.
- `busy` out, 1: a wash or spin phase is being timed.
- `remaining` out, CNT_W: ticks left in the current phase; 0 when idle.

## Operation
- FSM states: IDLE, WASH, WASH_DONE, SPIN, SPIN_DONE.
- IDLE → WASH when `run_wash`=1. Else IDLE → SPIN when `run_spin`=1. Wash has priority when both are high.
- On phase entry:
  - The duration is latched from the mode table, or from `cfg_*` in mode 11.
  - `mode_sel` and `cfg_*` changes during a phase are ignored.
- Mode table (wash/spin ticks): quick 600/120, normal 1200/300, heavy 1800/600.
- A latched duration of 0 is treated as 1.
- Prescaler:
  - Counts 0..TICK_DIV-1 and is cleared on phase entry.
  - One tick is produced when it wraps.
  - `remaining` decrements once per tick.
- WASH → WASH_DONE when `remaining` reaches 0. `cycle_time_out`=1 while in WASH_DONE.
- WASH_DONE → IDLE when `run_wash`=0.
- SPIN, SPIN_DONE and `spin_time_out` behave the same way, keyed on `run_spin`.
- Abort: a request dropping in WASH or SPIN returns the FSM to IDLE next cycle. `remaining` and the prescaler clear, and no timeout is asserted.
- `busy`=1 in WASH and SPIN only.
- Watchdog (when compiled in):
  - Independent fill and drain tick counters run while their input is high, sharing a free-running prescaler. Each counter clears when its input is low.
  - The fault sets when the count exceeds its limit.
  - A limit of 0 disables that watchdog.
  - Faults are sticky. `fault_clr` clears both faults and both counters.
  - If a set condition and `fault_clr` occur in the same cycle, set wins.
- Counters saturate at all-ones; they never wrap.

## Timing
- Reset values, applied synchronously while `reset`=0:
  - FSM in IDLE; all counters 0.
  - `cycle_time_out`, `spin_time_out`, `fill_fault`, `drain_fault` and `busy` are 0; `remaining`=0.
- All outputs are registered; no combinational path from input to output.
- Request seen high at edge E0: `busy`=1 from E0.
- Timeout goes high at E0 + N·TICK_DIV, where N is the latched duration.
- Request falls at edge Ef: the timeout clears at Ef.
- Reset mid-phase: IDLE at the next edge, outputs cleared, latched duration discarded.
- A request held through `reset` starts a new phase on the first edge after `reset` deasserts.

## Configuration
- `WASH_TIMER_WATCHDOG_EN` defined: the fill and drain watchdog logic is built.
- Undefined:
  - No watchdog registers.
  - `fill_fault`=`drain_fault`=0 constantly.
  - `cfg_fill_limit`, `cfg_drain_limit`, `fill_active`, `drain_active` and `fault_clr` are ignored.

## Test plan
- All tests use TICK_DIV=4.
- Mode 11, `cfg_wash_ticks`=3, `run_wash` held high → `cycle_time_out` rises exactly 12 clocks after entry; `remaining` steps 3, 2, 1, 0; timeout clears one edge after `run_wash` falls.
- Mode 00, `run_spin`=1 → `spin_time_out` after 480 clocks; a `mode_sel` change to 10 mid-phase has no effect.
- `run_wash` and `run_spin` rise together → WASH is taken. `run_wash` dropped after 5 clocks → IDLE; `remaining`=0; no timeout pulse.
- Custom duration 0 → `cycle_time_out` after 4 clocks.
- With the macro defined: `cfg_fill_limit`=2 and `fill_active` held → `fill_fault`=1 after the 3rd tick, sticky after `fill_active` falls, cleared by `fault_clr`. With the macro undefined, `fill_fault` stays 0.
- `reset` driven low in WASH with `remaining`=2 → all outputs 0 at the next edge; restart after release gives the full duration.

Source files
------------

// File: rtl/wash_cycle_timer.sv
// Phase timer for the wash/spin sequencer, plus an optional fill/drain watchdog.
// Define WASH_TIMER_WATCHDOG_EN to build the watchdog; otherwise both fault outputs are tied low.
module wash_cycle_timer #(
  parameter int TICK_DIV = 1000,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode_sel,
  input  logic [CNT_W-1:0] cfg_wash_ticks,
  input  logic [CNT_W-1:0] cfg_spin_ticks,
  input  logic [CNT_W-1:0] cfg_fill_limit,
  input  logic [CNT_W-1:0] cfg_drain_limit,
  input  logic             run_wash,
  input  logic             run_spin,
  input  logic             fill_active,
  input  logic             drain_active,
  input  logic             fault_clr,
  output logic             cycle_time_out,
  output logic             spin_time_out,
  output logic             fill_fault,
  output logic             drain_fault,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0] QUICK_WASH  = CNT_W'(600);
  localparam logic [CNT_W-1:0] QUICK_SPIN  = CNT_W'(120);
  localparam logic [CNT_W-1:0] NORMAL_WASH = CNT_W'(1200);
  localparam logic [CNT_W-1:0] NORMAL_SPIN = CNT_W'(300);
  localparam logic [CNT_W-1:0] HEAVY_WASH  = CNT_W'(1800);
  localparam logic [CNT_W-1:0] HEAVY_SPIN  = CNT_W'(600);

  typedef enum logic [2:0] {
    IDLE,
    WASH,
    WASH_DONE,
    SPIN,
    SPIN_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             cycle_to_q, cycle_to_d;
  logic             spin_to_q, spin_to_d;
  logic             busy_q, busy_d;

  logic             presc_wrap;
  logic [CNT_W-1:0] wash_sel, spin_sel;
  logic [CNT_W-1:0] wash_dur, spin_dur;

  always_comb begin
    wash_sel = cfg_wash_ticks;
    spin_sel = cfg_spin_ticks;
    case (mode_sel)
      2'b00: begin
        wash_sel = QUICK_WASH;
        spin_sel = QUICK_SPIN;
      end
      2'b01: begin
        wash_sel = NORMAL_WASH;
        spin_sel = NORMAL_SPIN;
      end
      2'b10: begin
        wash_sel = HEAVY_WASH;
        spin_sel = HEAVY_SPIN;
      end
      default: begin
        wash_sel = cfg_wash_ticks;
        spin_sel = cfg_spin_ticks;
      end
    endcase
    // A zero duration would never count down, so it is promoted to one tick.
    wash_dur = (wash_sel == '0) ? CNT_W'(1) : wash_sel;
    spin_dur = (spin_sel == '0) ? CNT_W'(1) : spin_sel;
  end

  always_comb begin
    state_d     = state_q;
    presc_wrap  = (presc_q == PW'(TICK_DIV - 1));
    presc_d     = presc_wrap ? '0 : presc_q + PW'(1);
    remaining_d = remaining_q;

    case (state_q)
      IDLE: begin
        presc_d     = '0;
        remaining_d = '0;
        if (run_wash) begin
          state_d     = WASH;
          remaining_d = wash_dur;
        end else if (run_spin) begin
          state_d     = SPIN;
          remaining_d = spin_dur;
        end
      end
      WASH, SPIN: begin
        if ((state_q == WASH) ? !run_wash : !run_spin) begin
          state_d     = IDLE;
          presc_d     = '0;
          remaining_d = '0;
        end else if (presc_wrap && remaining_q != '0) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = (state_q == WASH) ? WASH_DONE : SPIN_DONE;
            presc_d = '0;
          end
        end
      end
      WASH_DONE: begin
        presc_d     = '0;
        remaining_d = '0;
        if (!run_wash) state_d = IDLE;
      end
      SPIN_DONE: begin
        presc_d     = '0;
        remaining_d = '0;
        if (!run_spin) state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        presc_d     = '0;
        remaining_d = '0;
      end
    endcase

    busy_d     = (state_d == WASH) || (state_d == SPIN);
    cycle_to_d = (state_d == WASH_DONE);
    spin_to_d  = (state_d == SPIN_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      remaining_q <= '0;
      cycle_to_q  <= 1'b0;
      spin_to_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      remaining_q <= remaining_d;
      cycle_to_q  <= cycle_to_d;
      spin_to_q   <= spin_to_d;
      busy_q      <= busy_d;
    end
  end

  assign cycle_time_out = cycle_to_q;
  assign spin_time_out  = spin_to_q;
  assign busy           = busy_q;
  assign remaining      = remaining_q;

`ifdef WASH_TIMER_WATCHDOG_EN
  logic [PW-1:0]    wd_presc_q, wd_presc_d;
  logic             wd_tick;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d, fill_inc;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d, drain_inc;
  logic             fill_fault_q, fill_fault_d, fill_set;
  logic             drain_fault_q, drain_fault_d, drain_set;

  // The set test uses the post-increment count so a simultaneous fault_clr cannot mask it.
  always_comb begin
    wd_tick    = (wd_presc_q == PW'(TICK_DIV - 1));
    wd_presc_d = wd_tick ? '0 : wd_presc_q + PW'(1);

    fill_inc  = (wd_tick && fill_cnt_q != '1) ? fill_cnt_q + CNT_W'(1) : fill_cnt_q;
    drain_inc = (wd_tick && drain_cnt_q != '1) ? drain_cnt_q + CNT_W'(1) : drain_cnt_q;

    fill_set  = fill_active && (cfg_fill_limit != '0) && (fill_inc > cfg_fill_limit);
    drain_set = drain_active && (cfg_drain_limit != '0) && (drain_inc > cfg_drain_limit);

    fill_cnt_d  = (fault_clr || !fill_active) ? '0 : fill_inc;
    drain_cnt_d = (fault_clr || !drain_active) ? '0 : drain_inc;

    fill_fault_d  = fill_set || (fill_fault_q && !fault_clr);
    drain_fault_d = drain_set || (drain_fault_q && !fault_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_presc_q    <= '0;
      fill_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      fill_fault_q  <= 1'b0;
      drain_fault_q <= 1'b0;
    end else begin
      wd_presc_q    <= wd_presc_d;
      fill_cnt_q    <= fill_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      fill_fault_q  <= fill_fault_d;
      drain_fault_q <= drain_fault_d;
    end
  end

  assign fill_fault  = fill_fault_q;
  assign drain_fault = drain_fault_q;
`else
  logic unused_wd;
  assign unused_wd   = ^{cfg_fill_limit, cfg_drain_limit, fill_active, drain_active, fault_clr};
  assign fill_fault  = 1'b0;
  assign drain_fault = 1'b0;
`endif

endmodule

// File: tb/tb_wash_cycle_timer.sv
// Randomized bench for wash_cycle_timer, scored against a phase-deadline model kept in the bench.
// Fault expectations follow WASH_TIMER_WATCHDOG_EN as the design does.
module tb_wash_cycle_timer;

  localparam int TD    = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic [1:0]       mode_sel;
  logic [CNT_W-1:0] cfg_wash_ticks, cfg_spin_ticks, cfg_fill_limit, cfg_drain_limit;
  logic             run_wash, run_spin, fill_active, drain_active, fault_clr;
  logic             cycle_time_out, spin_time_out, fill_fault, drain_fault, busy;
  logic [CNT_W-1:0] remaining;

  int vectors     = 0;
  int miscompares = 0;

  // Model: which phase is active (0 none, 1 wash, 2 spin), the edge it started on and its length.
  int cyc     = 0;
  int m_kind  = 0;
  int m_entry = 0;
  int m_n     = 0;
  int wd_k    = 0;
  int f_cnt   = 0;
  int d_cnt   = 0;
  bit f_fault = 0;
  bit d_fault = 0;

  wash_cycle_timer #(.TICK_DIV(TD), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .mode_sel       (mode_sel),
    .cfg_wash_ticks (cfg_wash_ticks),
    .cfg_spin_ticks (cfg_spin_ticks),
    .cfg_fill_limit (cfg_fill_limit),
    .cfg_drain_limit(cfg_drain_limit),
    .run_wash       (run_wash),
    .run_spin       (run_spin),
    .fill_active    (fill_active),
    .drain_active   (drain_active),
    .fault_clr      (fault_clr),
    .cycle_time_out (cycle_time_out),
    .spin_time_out  (spin_time_out),
    .fill_fault     (fill_fault),
    .drain_fault    (drain_fault),
    .busy           (busy),
    .remaining      (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int duration(input logic [1:0] mode, input bit spin, input int cfg);
    int d;
    case (mode)
      2'b00:   d = spin ? 120 : 600;
      2'b01:   d = spin ? 300 : 1200;
      2'b10:   d = spin ? 600 : 1800;
      default: d = cfg;
    endcase
    return (d == 0) ? 1 : d;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", tag, cyc, observed, expected);
    end
  endtask

  task automatic modelEdge();
    bit tick, f_set, d_set;
    int f_inc, d_inc;
    cyc++;
    if (!reset) begin
      m_kind  = 0;
      wd_k    = 0;
      f_cnt   = 0;
      d_cnt   = 0;
      f_fault = 0;
      d_fault = 0;
    end else begin
      if (m_kind == 0) begin
        if (run_wash) begin
          m_kind  = 1;
          m_entry = cyc;
          m_n     = duration(mode_sel, 1'b0, int'(cfg_wash_ticks));
        end else if (run_spin) begin
          m_kind  = 2;
          m_entry = cyc;
          m_n     = duration(mode_sel, 1'b1, int'(cfg_spin_ticks));
        end
      end else if ((m_kind == 1 && !run_wash) || (m_kind == 2 && !run_spin)) begin
        m_kind = 0;
      end
      wd_k++;
      tick  = (wd_k % TD) == 0;
      f_inc = f_cnt + int'(tick);
      d_inc = d_cnt + int'(tick);
      f_set = fill_active && cfg_fill_limit != 0 && f_inc > int'(cfg_fill_limit);
      d_set = drain_active && cfg_drain_limit != 0 && d_inc > int'(cfg_drain_limit);
      f_cnt = (fault_clr || !fill_active) ? 0 : f_inc;
      d_cnt = (fault_clr || !drain_active) ? 0 : d_inc;
      f_fault = f_set || (f_fault && !fault_clr);
      d_fault = d_set || (d_fault && !fault_clr);
    end
  endtask

  task automatic checkAll();
    int elapsed;
    bit fin, e_busy;
    elapsed = cyc - m_entry;
    fin     = (m_kind != 0) && (elapsed >= m_n * TD);
    e_busy  = (m_kind != 0) && !fin;
    checkOutput("busy", 32'(busy), 32'(e_busy));
    checkOutput("cycle_time_out", 32'(cycle_time_out), 32'(m_kind == 1 && fin));
    checkOutput("spin_time_out", 32'(spin_time_out), 32'(m_kind == 2 && fin));
    checkOutput("remaining", 32'(remaining), e_busy ? 32'(m_n - elapsed / TD) : 32'd0);
`ifdef WASH_TIMER_WATCHDOG_EN
    checkOutput("fill_fault", 32'(fill_fault), 32'(f_fault));
    checkOutput("drain_fault", 32'(drain_fault), 32'(d_fault));
`else
    checkOutput("fill_fault", 32'(fill_fault), 32'd0);
    checkOutput("drain_fault", 32'(drain_fault), 32'd0);
`endif
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      modelEdge();
      #1;
      checkAll();
    end
  endtask

  initial begin
    reset = 1'b0;
    mode_sel = 2'b11;
    cfg_wash_ticks = '0;
    cfg_spin_ticks = '0;
    cfg_fill_limit = '0;
    cfg_drain_limit = '0;
    run_wash = 1'b0;
    run_spin = 1'b0;
    fill_active = 1'b0;
    drain_active = 1'b0;
    fault_clr = 1'b0;

    applyStimulus(3);
    reset = 1'b1;
    applyStimulus(2);

    $display("[TB] custom wash of 3 ticks");
    cfg_wash_ticks = 16'd3;
    run_wash = 1'b1;
    applyStimulus(15);
    run_wash = 1'b0;
    applyStimulus(3);

    $display("[TB] quick spin with mid-phase mode change");
    mode_sel = 2'b00;
    run_spin = 1'b1;
    applyStimulus(100);
    mode_sel = 2'b10;
    applyStimulus(390);
    run_spin = 1'b0;
    applyStimulus(3);

    $display("[TB] simultaneous requests, wash aborted");
    mode_sel = 2'b11;
    cfg_wash_ticks = 16'd6;
    cfg_spin_ticks = 16'd2;
    run_wash = 1'b1;
    run_spin = 1'b1;
    applyStimulus(5);
    run_wash = 1'b0;
    run_spin = 1'b0;
    applyStimulus(3);

    $display("[TB] zero custom duration");
    cfg_wash_ticks = 16'd0;
    run_wash = 1'b1;
    applyStimulus(6);
    run_wash = 1'b0;
    applyStimulus(2);

    $display("[TB] fill watchdog");
    cfg_fill_limit = 16'd2;
    fill_active = 1'b1;
    applyStimulus(16);
    fill_active = 1'b0;
    applyStimulus(4);
    fault_clr = 1'b1;
    applyStimulus(1);
    fault_clr = 1'b0;
    drain_active = 1'b1;
    applyStimulus(16);
    cfg_drain_limit = 16'd1;
    applyStimulus(12);
    drain_active = 1'b0;
    fault_clr = 1'b1;
    applyStimulus(1);
    fault_clr = 1'b0;
    applyStimulus(2);

    $display("[TB] reset in the middle of a wash");
    cfg_wash_ticks = 16'd5;
    run_wash = 1'b1;
    applyStimulus(13);
    reset = 1'b0;
    applyStimulus(1);
    reset = 1'b1;
    applyStimulus(24);
    run_wash = 1'b0;
    applyStimulus(2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0) mode_sel = ($urandom_range(7) == 0) ? 2'($urandom_range(2)) : 2'b11;
      if ($urandom_range(31) == 0) cfg_wash_ticks = 16'($urandom_range(6));
      if ($urandom_range(31) == 0) cfg_spin_ticks = 16'($urandom_range(6));
      if ($urandom_range(63) == 0) cfg_fill_limit = 16'($urandom_range(3));
      if ($urandom_range(63) == 0) cfg_drain_limit = 16'($urandom_range(3));
      if ($urandom_range(19) == 0) run_wash = ~run_wash;
      if ($urandom_range(19) == 0) run_spin = ~run_spin;
      if ($urandom_range(11) == 0) fill_active = ~fill_active;
      if ($urandom_range(11) == 0) drain_active = ~drain_active;
      fault_clr = ($urandom_range(39) == 0);
      reset = ($urandom_range(299) != 0);
      applyStimulus(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
